alu_decode_stage: RTL and testbench

- Registered instruction-decode stage that produces the 3-bit ALU operation code and operand-select controls consumed by the EX-stage ALU.
- Sits between IF/ID and EX in the pipelined MIPS core.
- Accepts a 32-bit instruction word over a valid/ready handshake, decodes opcode/funct, and holds the decoded bundle in an output register with stall (backpressure) and flush support.

---
 rtl/alu_decode_stage_if.sv | 33 +++
 rtl/alu_decode_stage.sv | 192 +++++++++++++++++++
 tb/tb_alu_decode_stage.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_decode_stage_if.sv
// Handshake and decoded-bundle signals between IF/ID, the ALU decode stage and EX.
// master drives the instruction side and consumes the bundle; slave is the decode stage.
interface alu_decode_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  alucontrol;
    logic        asel_shamt;
    logic        alusrc;
    logic [31:0] imm_ext;
    logic [4:0]  shamt;
    logic        regwrite;
    logic        regdst;
    logic        memtoreg;
    logic        memwrite;
    logic        branch;
    logic        illegal;

    modport master (
        output in_valid, instr, flush, out_ready,
        input  in_ready, out_valid, alucontrol, asel_shamt, alusrc, imm_ext, shamt,
               regwrite, regdst, memtoreg, memwrite, branch, illegal
    );

    modport slave (
        input  in_valid, instr, flush, out_ready,
        output in_ready, out_valid, alucontrol, asel_shamt, alusrc, imm_ext, shamt,
               regwrite, regdst, memtoreg, memwrite, branch, illegal
    );
endinterface

// File: rtl/alu_decode_stage.sv
// Registered MIPS decode stage: opcode/funct -> ALU op and operand/writeback controls.
// Define ALU_DECODE_ILLEGAL_CNT_EN to add a saturating illegal-instruction counter.
module alu_decode_stage #(
    parameter int unsigned IMM_W = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    alu_decode_stage_if.slave   bus
`ifdef ALU_DECODE_ILLEGAL_CNT_EN
    ,
    output logic [15:0]         illegal_cnt
`endif
);

    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluOr  = 3'b001;
    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluSll = 3'b011;
    localparam logic [2:0] AluSrl = 3'b100;
    localparam logic [2:0] AluSub = 3'b110;
    localparam logic [2:0] AluSlt = 3'b111;

    typedef struct packed {
        logic [2:0]  alucontrol;
        logic        asel_shamt;
        logic        alusrc;
        logic [31:0] imm_ext;
        logic [4:0]  shamt;
        logic        regwrite;
        logic        regdst;
        logic        memtoreg;
        logic        memwrite;
        logic        branch;
        logic        illegal;
    } bundle_t;

    bundle_t     bundle_d, bundle_q, dec;
    logic        out_valid_d, out_valid_q;
    logic        accept;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic        unused_instr;

    assign opcode       = bus.instr[31:26];
    assign funct        = bus.instr[5:0];
    assign imm_sext     = {{(32 - IMM_W){bus.instr[IMM_W-1]}}, bus.instr[IMM_W-1:0]};
    assign imm_zext     = {{(32 - IMM_W){1'b0}}, bus.instr[IMM_W-1:0]};
    assign unused_instr = ^bus.instr[25:16];

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        dec         = '0;
        dec.imm_ext = imm_sext;
        dec.shamt   = bus.instr[10:6];
        case (opcode)
            6'h00: begin
                dec.regwrite = 1'b1;
                dec.regdst   = 1'b1;
                case (funct)
                    6'h20: dec.alucontrol = AluAdd;
                    6'h22: dec.alucontrol = AluSub;
                    6'h24: dec.alucontrol = AluAnd;
                    6'h25: dec.alucontrol = AluOr;
                    6'h2A: dec.alucontrol = AluSlt;
                    6'h00: begin
                        dec.alucontrol = AluSll;
                        dec.asel_shamt = 1'b1;
                    end
                    6'h02: begin
                        dec.alucontrol = AluSrl;
                        dec.asel_shamt = 1'b1;
                    end
                    default: begin
                        // Unsupported funct becomes a side-effect-free NOP
                        dec.regwrite   = 1'b0;
                        dec.regdst     = 1'b0;
                        dec.illegal    = 1'b1;
                        dec.alucontrol = AluAdd;
                    end
                endcase
            end
            6'h23: begin
                dec.alucontrol = AluAdd;
                dec.alusrc     = 1'b1;
                dec.regwrite   = 1'b1;
                dec.memtoreg   = 1'b1;
            end
            6'h2B: begin
                dec.alucontrol = AluAdd;
                dec.alusrc     = 1'b1;
                dec.memwrite   = 1'b1;
            end
            6'h04: begin
                dec.alucontrol = AluSub;
                dec.branch     = 1'b1;
            end
            6'h08: begin
                dec.alucontrol = AluAdd;
                dec.alusrc     = 1'b1;
                dec.regwrite   = 1'b1;
            end
            6'h0A: begin
                dec.alucontrol = AluSlt;
                dec.alusrc     = 1'b1;
                dec.regwrite   = 1'b1;
            end
            6'h0C: begin
                dec.alucontrol = AluAnd;
                dec.alusrc     = 1'b1;
                dec.regwrite   = 1'b1;
                dec.imm_ext    = imm_zext;
            end
            6'h0D: begin
                dec.alucontrol = AluOr;
                dec.alusrc     = 1'b1;
                dec.regwrite   = 1'b1;
                dec.imm_ext    = imm_zext;
            end
            default: begin
                dec.illegal    = 1'b1;
                dec.alucontrol = AluAdd;
            end
        endcase
    end

    always_comb begin
        bundle_d    = bundle_q;
        out_valid_d = out_valid_q;
        if (bus.flush) begin
            // Squash: drop any incoming word and kill side-effecting controls
            out_valid_d       = 1'b0;
            bundle_d.regwrite = 1'b0;
            bundle_d.memwrite = 1'b0;
            bundle_d.branch   = 1'b0;
            bundle_d.illegal  = 1'b0;
        end else if (accept) begin
            bundle_d    = dec;
            out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bundle_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            bundle_q    <= bundle_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.alucontrol = bundle_q.alucontrol;
    assign bus.asel_shamt = bundle_q.asel_shamt;
    assign bus.alusrc     = bundle_q.alusrc;
    assign bus.imm_ext    = bundle_q.imm_ext;
    assign bus.shamt      = bundle_q.shamt;
    assign bus.regwrite   = bundle_q.regwrite;
    assign bus.regdst     = bundle_q.regdst;
    assign bus.memtoreg   = bundle_q.memtoreg;
    assign bus.memwrite   = bundle_q.memwrite;
    assign bus.branch     = bundle_q.branch;
    assign bus.illegal    = bundle_q.illegal;

`ifdef ALU_DECODE_ILLEGAL_CNT_EN
    logic [15:0] illegal_cnt_d, illegal_cnt_q;

    always_comb begin
        illegal_cnt_d = illegal_cnt_q;
        if (accept && !bus.flush && dec.illegal && (illegal_cnt_q != 16'hFFFF)) begin
            illegal_cnt_d = illegal_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            illegal_cnt_q <= '0;
        end else begin
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign illegal_cnt = illegal_cnt_q;
`endif

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed self-checking bench for alu_decode_stage; covers the illegal counter when
// ALU_DECODE_ILLEGAL_CNT_EN is defined.
module tb_alu_decode_stage;

    logic clk;
    logic reset_n;
    int   errors;
    int   checks;

    alu_decode_stage_if bus ();

`ifdef ALU_DECODE_ILLEGAL_CNT_EN
    logic [15:0] illegal_cnt;
`endif

    alu_decode_stage #(
        .IMM_W (16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus.slave)
`ifdef ALU_DECODE_ILLEGAL_CNT_EN
        ,
        .illegal_cnt (illegal_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word with EX always ready, then sample the registered bundle.
    task automatic send(input logic [31:0] w);
        bus.instr     = w;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        bus.flush     = 1'b0;
        tick();
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.instr     = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_alucontrol", 32'(bus.alucontrol), 32'd0);
        chk("rst_regwrite", 32'(bus.regwrite), 32'd0);
        chk("rst_illegal", 32'(bus.illegal), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        reset_n = 1'b1;
        tick();

        // add $3,$1,$2
        send(32'h00221820);
        chk("add_valid", 32'(bus.out_valid), 32'd1);
        chk("add_alu", 32'(bus.alucontrol), 32'b010);
        chk("add_regdst", 32'(bus.regdst), 32'd1);
        chk("add_regwrite", 32'(bus.regwrite), 32'd1);
        chk("add_alusrc", 32'(bus.alusrc), 32'd0);
        chk("add_asel", 32'(bus.asel_shamt), 32'd0);

        // lw held under backpressure while sub waits
        send(32'h8C220004);
        bus.out_ready = 1'b0;
        bus.instr     = 32'h00221822;
        #1;
        chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_alu", 32'(bus.alucontrol), 32'b010);
            chk("stall_alusrc", 32'(bus.alusrc), 32'd1);
            chk("stall_imm", bus.imm_ext, 32'h00000004);
            chk("stall_memtoreg", 32'(bus.memtoreg), 32'd1);
            chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("release_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        chk("sub_alu", 32'(bus.alucontrol), 32'b110);
        chk("sub_regdst", 32'(bus.regdst), 32'd1);
        chk("sub_memtoreg", 32'(bus.memtoreg), 32'd0);
        bus.in_valid = 1'b0;
        tick();
        chk("drain_valid", 32'(bus.out_valid), 32'd0);

        // extension and shift forms
        send(32'h3022FFFF);
        chk("andi_imm", bus.imm_ext, 32'h0000FFFF);
        chk("andi_alu", 32'(bus.alucontrol), 32'b000);
        chk("andi_alusrc", 32'(bus.alusrc), 32'd1);
        send(32'h2822FFFF);
        chk("slti_imm", bus.imm_ext, 32'hFFFFFFFF);
        chk("slti_alu", 32'(bus.alucontrol), 32'b111);
        send(32'h00021100);
        chk("sll_alu", 32'(bus.alucontrol), 32'b011);
        chk("sll_asel", 32'(bus.asel_shamt), 32'd1);
        chk("sll_shamt", 32'(bus.shamt), 32'd4);
        send(32'h00021102);
        chk("srl_alu", 32'(bus.alucontrol), 32'b100);
        chk("srl_asel", 32'(bus.asel_shamt), 32'd1);
        send(32'h00221825);
        chk("or_alu", 32'(bus.alucontrol), 32'b001);
        chk("or_asel", 32'(bus.asel_shamt), 32'd0);
        send(32'h00221824);
        chk("and_alu", 32'(bus.alucontrol), 32'b000);
        send(32'h0022182A);
        chk("slt_alu", 32'(bus.alucontrol), 32'b111);
        send(32'hAC220008);
        chk("sw_memwrite", 32'(bus.memwrite), 32'd1);
        chk("sw_regwrite", 32'(bus.regwrite), 32'd0);
        chk("sw_alu", 32'(bus.alucontrol), 32'b010);
        chk("sw_imm", bus.imm_ext, 32'h00000008);
        send(32'h10220003);
        chk("beq_branch", 32'(bus.branch), 32'd1);
        chk("beq_alu", 32'(bus.alucontrol), 32'b110);
        chk("beq_alusrc", 32'(bus.alusrc), 32'd0);
        send(32'h3422FFFF);
        chk("ori_imm", bus.imm_ext, 32'h0000FFFF);
        chk("ori_alu", 32'(bus.alucontrol), 32'b001);
        send(32'h2022FFFE);
        chk("addi_imm", bus.imm_ext, 32'hFFFFFFFE);
        chk("addi_regwrite", 32'(bus.regwrite), 32'd1);
        chk("addi_regdst", 32'(bus.regdst), 32'd0);
        send(32'h00000000);
        chk("nop_illegal", 32'(bus.illegal), 32'd0);
        chk("nop_regwrite", 32'(bus.regwrite), 32'd1);
        chk("nop_alu", 32'(bus.alucontrol), 32'b011);

        // flush squashes the held entry and the coincident beq
        send(32'h8C220004);
        bus.flush     = 1'b1;
        bus.out_ready = 1'b0;
        bus.instr     = 32'h10220003;
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_branch", 32'(bus.branch), 32'd0);
        chk("flush_regwrite", 32'(bus.regwrite), 32'd0);

        // illegal encodings
        send(32'hFC000000);
        chk("ill_op_illegal", 32'(bus.illegal), 32'd1);
        chk("ill_op_regwrite", 32'(bus.regwrite), 32'd0);
        chk("ill_op_memwrite", 32'(bus.memwrite), 32'd0);
        chk("ill_op_branch", 32'(bus.branch), 32'd0);
        chk("ill_op_alu", 32'(bus.alucontrol), 32'b010);
        send(32'h00221821);
        chk("ill_fn_illegal", 32'(bus.illegal), 32'd1);
        chk("ill_fn_regwrite", 32'(bus.regwrite), 32'd0);
        send(32'h00221820);
        chk("legal_after_ill", 32'(bus.illegal), 32'd0);
        bus.flush = 1'b1;
        bus.instr = 32'hFC000000;
        tick();
        bus.flush = 1'b0;
        chk("ill_flush_illegal", 32'(bus.illegal), 32'd0);
        chk("ill_flush_valid", 32'(bus.out_valid), 32'd0);

        // asynchronous reset while a bundle is held
        send(32'h00221820);
        bus.in_valid = 1'b0;
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst_alu", 32'(bus.alucontrol), 32'd0);
        chk("async_rst_regwrite", 32'(bus.regwrite), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

`ifdef ALU_DECODE_ILLEGAL_CNT_EN
        chk("cnt_reset", 32'(illegal_cnt), 32'd0);
        send(32'hFC000000);
        send(32'h00221821);
        send(32'hFC000000);
        send(32'h00221820);
        chk("cnt_three", 32'(illegal_cnt), 32'd3);
        bus.flush = 1'b1;
        bus.instr = 32'hFC000000;
        tick();
        bus.flush = 1'b0;
        chk("cnt_flush_skip", 32'(illegal_cnt), 32'd3);
        for (int i = 0; i < 65532; i++) begin
            send(32'hFC000000);
        end
        chk("cnt_full", 32'(illegal_cnt), 32'h0000FFFF);
        send(32'hFC000000);
        send(32'hFC000000);
        chk("cnt_saturate", 32'(illegal_cnt), 32'h0000FFFF);
`endif

        bus.in_valid = 1'b0;
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
